yolo_osif_axis: RTL
===================

YOLO_OSIF_AXIS -- requirements
Module: yolo_osif_axis

Interface
REQ-001 SHALL have parameter TBITS, default 32, giving the stream data width in bits.
REQ-002 SHALL have parameter TBYTE, default 4, giving the strobe width (TBITS/8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port osif_data_dout  input  TBITS  FIFO head data, first-word-fall-through.
REQ-006 SHALL have port osif_strb_dout  input  TBYTE  FIFO head strobe.
REQ-007 SHALL have port osif_last_dout  input  1  FIFO head end-of-packet flag.
REQ-008 SHALL have port osif_user_dout  input  1  FIFO head sideband flag.
REQ-009 SHALL have port osif_empty_n  input  1  FIFO head valid.
REQ-010 SHALL have port osif_read  output  1  pops the FIFO head this cycle.
REQ-011 SHALL have ports m_axis_tdata  output TBITS, m_axis_tstrb  output TBYTE, m_axis_tlast  output 1, m_axis_tuser  output 1: the AXI4-Stream master beat.
REQ-012 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream accept.

Function
REQ-014 SHALL hold beats in two registered slots, main (drives m_axis_*) and skid, each storing {data,strb,last,user}.
REQ-015 SHALL use an occupancy FSM with states IDLE (0 beats), BUSY (main full) and FULL (main and skid full).
REQ-016 SHALL drive osif_read = osif_empty_n AND (state != FULL), with no combinational path from m_axis_tready.
REQ-017 SHALL define rd = osif_read and acc = m_axis_tvalid AND m_axis_tready.
REQ-018 SHALL take these transitions from IDLE: rd -> BUSY (load main); else stay IDLE.
REQ-019 SHALL take these transitions from BUSY: rd & acc -> BUSY (reload main); rd & !acc -> FULL (load skid); !rd & acc -> IDLE; else stay BUSY.
REQ-020 SHALL take these transitions from FULL: acc -> BUSY (skid copied to main); else stay FULL, with osif_read = 0.
REQ-021 SHALL assert m_axis_tvalid exactly when state is BUSY or FULL.
REQ-022 SHALL have a latency of 1 cycle from FIFO pop to m_axis_tvalid.
REQ-023 SHALL sustain 1 beat per cycle while tready is held high and the FIFO is non-empty.
REQ-024 SHALL pass data, strb, last and user unmodified, in FIFO order, with no beat dropped or duplicated.
REQ-025 SHALL keep all m_axis_* outputs stable while tvalid=1 and tready=0 (AXI rule).
REQ-026 SHALL treat tready toggling every cycle, and the FIFO going empty mid-packet, as legal; tvalid drops only when both slots drain.

Reset
REQ-027 SHALL, while rst=0, force state to IDLE, tvalid to 0, tdata, tstrb, tlast and tuser to 0, and both slots to 0.
REQ-028 SHALL drive osif_read = 0 during reset.
REQ-029 SHALL, on reset asserted mid-packet, discard in-flight beats, and SHALL NOT re-emit them after reset releases.
REQ-030 SHALL resume operation on the first clk edge after rst deasserts.

Configuration
REQ-031 SHALL support macro YOLO_OSIF_AXIS_STAT_EN.
REQ-032 SHALL, when YOLO_OSIF_AXIS_STAT_EN is defined, add output stat_beat_cnt (32 bits, +1 per acc, wraps 2^32-1 -> 0).
REQ-033 SHALL, when YOLO_OSIF_AXIS_STAT_EN is defined, add output stat_pkt_cnt (16 bits, +1 per acc with tlast=1, wraps 0xFFFF -> 0).
REQ-034 SHALL reset both stat counters to 0.
REQ-035 SHALL, when YOLO_OSIF_AXIS_STAT_EN is undefined, omit the stat ports and counters, with stream behaviour identical.

Structure
REQ-036 SHALL place the FSM state encodings (IDLE=2'd0, BUSY=2'd1, FULL=2'd2) and the TBITS/TBYTE defaults in shared package yolo_pkg.
REQ-037 SHALL use one sub-module, yolo_beat_reg, instantiated twice for the main and skid slots, with async active-low clear and load enable.

Verification
REQ-038 SHALL cover: reset, then FIFO holds 0x1,0x2,0x3 (last on 0x3), tready=1 -> tvalid rises 1 cycle after first pop; beats 0x1,0x2,0x3 on consecutive cycles; tlast only with 0x3.
REQ-039 SHALL cover: tready=0 with 5 beats in the FIFO -> exactly 2 pops, state FULL, osif_read=0, tdata=first beat held stable.
REQ-040 SHALL cover: tready alternating 1/0 for 100 random beats -> output sequence matches the FIFO sequence exactly, including strb/user.
REQ-041 SHALL cover: rst=0 asserted in FULL with beat 0xA in main -> tvalid=0 immediately (async), and 0xA is never output after release.
REQ-042 SHALL cover: the FIFO empty for 3 cycles mid-packet -> tvalid=0 gap, then the packet resumes in order with tlast on the final beat.
REQ-043 SHALL cover: with YOLO_OSIF_AXIS_STAT_EN, 3 packets of 4 beats -> stat_beat_cnt=12, stat_pkt_cnt=3; preload 0xFFFF then 1 packet -> stat_pkt_cnt=0.

Source files
------------

// File: rtl/yolo_pkg.sv
// Shared definitions for the FIFO-to-AXI4-Stream bridge: occupancy states and default widths.
`timescale 1ns/1ps
package yolo_pkg;
    localparam int TBITS_DEF = 32;
    localparam int TBYTE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;
endpackage

// File: rtl/yolo_beat_reg.sv
// One beat slot {data,strb,last,user}: loads on ld, clears asynchronously on rst low.
// Latency 1 cycle; no backpressure of its own.
`timescale 1ns/1ps
module yolo_beat_reg #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end
endmodule

// File: rtl/yolo_osif_axis.sv
// FWFT FIFO to AXI4-Stream master through a main+skid register pair; 1 cycle pop-to-tvalid.
// Backpressure: pops stop only when both slots are full, so osif_read never depends on tready.
// Optional beat/packet counters when YOLO_OSIF_AXIS_STAT_EN is defined.
`timescale 1ns/1ps
module yolo_osif_axis
    import yolo_pkg::*;
#(
    parameter int TBITS = TBITS_DEF,
    parameter int TBYTE = TBYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TBITS-1:0] osif_data_dout,
    input  logic [TBYTE-1:0] osif_strb_dout,
    input  logic             osif_last_dout,
    input  logic             osif_user_dout,
    input  logic             osif_empty_n,
    output logic             osif_read,
    output logic [TBITS-1:0] m_axis_tdata,
    output logic [TBYTE-1:0] m_axis_tstrb,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
`ifdef YOLO_OSIF_AXIS_STAT_EN
    ,
    output logic [31:0]      stat_beat_cnt,
    output logic [15:0]      stat_pkt_cnt
`endif
);
    localparam int BW = TBITS + TBYTE + 2;

    state_t          state;
    state_t          state_nx;
    logic            rd;
    logic            acc;
    logic            ld_main;
    logic            ld_skid;
    logic            main_from_skid;
    logic [BW-1:0]   fifo_beat;
    logic [BW-1:0]   main_d;
    logic [BW-1:0]   main_q;
    logic [BW-1:0]   skid_q;

    assign fifo_beat = {osif_data_dout, osif_strb_dout, osif_last_dout, osif_user_dout};
    // rst gating keeps the FIFO untouched while the bridge is held in reset.
    assign rd        = osif_empty_n & rst & (state != FULL);
    assign osif_read = rd;
    assign m_axis_tvalid = (state == BUSY) || (state == FULL);
    assign acc       = m_axis_tvalid & m_axis_tready;
    assign main_d    = main_from_skid ? skid_q : fifo_beat;
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tuser} = main_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        ld_main        = 1'b0;
        ld_skid        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            IDLE: begin
                if (rd) begin
                    state_nx = BUSY;
                    ld_main  = 1'b1;
                end
            end
            BUSY: begin
                if (rd && acc) begin
                    ld_main = 1'b1;
                end else if (rd) begin
                    state_nx = FULL;
                    ld_skid  = 1'b1;
                end else if (acc) begin
                    state_nx = IDLE;
                end
            end
            FULL: begin
                if (acc) begin
                    state_nx       = BUSY;
                    ld_main        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    yolo_beat_reg #(.W(BW)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (ld_main),
        .d   (main_d),
        .q   (main_q)
    );

    yolo_beat_reg #(.W(BW)) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (ld_skid),
        .d   (fifo_beat),
        .q   (skid_q)
    );

`ifdef YOLO_OSIF_AXIS_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_beat_cnt <= '0;
            stat_pkt_cnt  <= '0;
        end else if (acc) begin
            stat_beat_cnt <= stat_beat_cnt + 32'd1;
            if (m_axis_tlast) begin
                stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
            end
        end
    end
`endif
endmodule
